// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_if
// Brief    : Address/data/mode bundle for the register file; the master drives
//            the address, write data and mode, the slave returns read data.
// Revision : 1.0
// ============================================================================
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] dataIn;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  mode;

    modport master (
        output address,
        output dataIn,
        output mode,
        input  dataOut
    );

    modport slave (
        input  address,
        input  dataIn,
        input  mode,
        output dataOut
    );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Brief    : DEPTH x DATA_WIDTH register file, one shared address, synchronous
//            write, combinational read, synchronous clear.
// Revision : 1.0
// ============================================================================
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic       clk,
    input  wire logic       rst,
    register_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // Reset wins over a same-cycle write; address 0 is an ordinary register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.mode) begin
            regs[bus.address] <= bus.dataIn;
        end
    end

    // No write-through: a same-address write shows up only after the edge.
    assign bus.dataOut = regs[bus.address];
endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Brief    : Self-checking bench for register_file against an array model.
// Revision : 1.0
// ============================================================================
module tb_register_file;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] model [32];

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle mid-period, then apply the architectural rule to the model.
    task automatic step(input logic r, input logic m, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rst         = r;
        bus.mode    = m;
        bus.address = a;
        bus.dataIn  = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (m) begin
            model[a] = d;
        end
        #1;
        rst      = 1'b0;
        bus.mode = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a);
        bus.mode    = 1'b0;
        bus.address = a;
        #1;
        check(tag, bus.dataOut, model[a]);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) read_chk(tag, 5'(i));
    endtask

    initial begin
        rst         = 1'b1;
        bus.mode    = 1'b0;
        bus.address = '0;
        bus.dataIn  = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'hDEAD_BEEF;

        // Reset clears everything
        step(1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            bus.address = 5'(i);
            #1;
            check("reset_zero", bus.dataOut, 32'h0);
        end

        // Address 0 is writable
        step(1'b0, 1'b1, 5'd0, 32'd3216);
        bus.address = 5'd0;
        #1;
        check("addr0_write", bus.dataOut, 32'd3216);
        bus.address = 5'd1;
        #1;
        check("addr1_untouched", bus.dataOut, 32'd0);

        // Read-during-write: old value before the edge, new value after
        step(1'b0, 1'b1, 5'd5, 32'hAAAA_5555);
        @(negedge clk);
        bus.mode    = 1'b1;
        bus.address = 5'd5;
        bus.dataIn  = 32'h1234_5678;
        #1;
        check("rdw_before", bus.dataOut, 32'hAAAA_5555);
        @(posedge clk);
        model[5] = 32'h1234_5678;
        #1;
        bus.mode = 1'b0;
        check("rdw_after", bus.dataOut, 32'h1234_5678);

        // Full sweep, consecutive edges, distinct per-entry values
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101 + 32'd7);
        for (int i = 0; i < 32; i++) begin
            bus.address = 5'(i);
            #1;
            check("sweep_value", bus.dataOut, 32'(i) * 32'h0101_0101 + 32'd7);
        end
        step(1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF);
        read_chk("all_ones_31", 5'd31);
        read_chk("all_ones_30_kept", 5'd30);

        // Hold: mode=0 with random data never changes storage
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 5'($urandom_range(0, 31)), $urandom);
            read_chk("hold_edge", 5'($urandom_range(0, 31)));
        end
        sweep("hold_sweep");

        // Reset has priority over a same-cycle write
        step(1'b1, 1'b1, 5'd3, 32'd99);
        read_chk("rst_prio_3", 5'd3);
        sweep("rst_prio_sweep");

        // Randomized mix of writes, holds and occasional resets
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom_range(0, 31)), $urandom);
            read_chk("random_read", 5'($urandom_range(0, 31)));
        end
        sweep("random_sweep");

        // Reset mid-sequence clears the register written the cycle before
        step(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D);
        step(1'b0, 1'b1, 5'd10, 32'h0BAD_F00D);
        step(1'b1, 1'b0, 5'd0, 32'h0);
        read_chk("midrst_10", 5'd10);
        sweep("midrst_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the BUBBLE processor datapath.
- One shared address port, one write-data port and one read-data port; a mode bit selects write (1) or read-only (0).
- Writes are synchronous to clk; reads are combinational; a synchronous reset clears every entry.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the address port.
- DEPTH, 2**ADDR_WIDTH (32), number of registers. Every address is backed by storage.

Ports:
- clk  input  1  rising-edge clock for all state updates.
- rst  input  1  synchronous reset, active-high.
- address  input  ADDR_WIDTH  register index for both read and write.
- dataIn  input  DATA_WIDTH  write data.
- dataOut  output  DATA_WIDTH  read data, always the contents of regs[address].
- mode  input  1  1 = write dataIn into regs[address] at the next rising edge; 0 = no write.

Behaviour:
- Storage: DEPTH registers of DATA_WIDTH bits. There is no hardwired-zero register; address 0 is an ordinary writable register.
- Reset:
  - On a rising edge with rst=1, all DEPTH registers become 0.
  - rst has priority over mode: a write requested in the same cycle is discarded.
  - dataOut therefore reads 0 for every address after reset.
- Write:
  - On a rising edge with rst=0 and mode=1, regs[address] <= dataIn.
  - Exactly one register is updated per edge; all others hold.
- Hold: on a rising edge with rst=0 and mode=0, no register changes.
- Read:
  - dataOut = regs[address], purely combinational, with zero-cycle latency from an address change.
  - Read is independent of mode: dataOut stays valid while mode=1.
- Read-during-write (same address, mode=1):
  - Before the edge, dataOut shows the old stored value; there is no write-through bypass.
  - After the edge, dataOut shows dataIn.
- Width rules: dataIn is stored unmodified, with no sign or zero manipulation. The address is exactly ADDR_WIDTH bits and covers all DEPTH entries, so no out-of-range case exists.
- X/undefined inputs: none are required to be handled. Implementations must not infer latches.
- Reset mid-operation: asserting rst while a sequence of writes is in progress clears every register at that edge, including one written in the previous cycle.

Test Plan:
- Reset: rst=1 for one edge, then rst=0, mode=0, sweep address 0..31 -> dataOut=0 at every address.
- Write/read address 0: mode=1, address=0, dataIn=3216, one edge; then mode=0, address=0 -> dataOut=3216. Then address=1 -> dataOut=0.
- Read-during-write: regs[5]=0xAAAA5555; mode=1, address=5, dataIn=0x12345678 -> dataOut=0xAAAA5555 before the edge and 0x12345678 after it.
- Full sweep: write regs[i]=i*0x01010101+7 for i=0..31 on consecutive edges; read back all 32 -> each value matches and no entry is aliased. Also cover regs[31]=0xFFFFFFFF.
- Hold: with mode=0, toggle dataIn randomly for 10 edges across several addresses -> stored contents unchanged.
- Reset priority: rst=1 and mode=1, address=3, dataIn=99 on the same edge -> regs[3]=0 afterwards and all other entries 0.
